sync_fifo_param: RTL
====================

Name: sync_fifo_param

Overview:
Parametrised synchronous FIFO, successor to the team's fixed 8x8 FIFO. Width, depth and almost-full/almost-empty thresholds are set per instance. Adds a fill-level output, a read-valid strobe and a registered output that holds its value between reads. Used as the general-purpose single-clock buffer between producer/consumer blocks in the datapath.

Parameters:
DWIDTH, 8, data width in bits (>=1)
DEPTH, 8, number of entries; must be a power of 2, >=2
AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
we  in  1  write request
re  in  1  read request
din  in  DWIDTH  write data
dout  out  DWIDTH  registered read data
rd_valid  out  1  dout updated this cycle (1-cycle pulse)
count  out  AW+1  entries stored, 0..DEPTH (AW = log2(DEPTH))
empty  out  1  count == 0
full  out  1  count == DEPTH
almost_empty  out  1  count <= AE_LEVEL
almost_full  out  1  count >= AF_LEVEL
rd_err  out  1  read attempted while empty (1-cycle pulse)
wr_err  out  1  write attempted while full (1-cycle pulse)

Behaviour:
- Reset (async assert, sync to clk on release): rd_ptr=wr_ptr=0, count=0, dout=0, rd_valid=0, rd_err=wr_err=0, so empty=1, almost_empty=1, full=0, almost_full=0. Storage array is not reset.
- rst asserted mid-operation clears all state immediately. Stored data is discarded. First access after release behaves as on an empty FIFO.
- Pointers are AW bits wide and wrap DEPTH-1 -> 0 naturally. count is the single source of truth for flags.
- Flags are decoded combinationally from the registered count only, never from we/re. They change the cycle after the access.
- All state updates on the rising clk edge. Decision is by state {empty, full, partial} x {we, re}:
  - Partial, we only: mem[wr_ptr]<=din, wr_ptr++, count++.
  - Partial, re only: dout<=mem[rd_ptr], rd_valid=1, rd_ptr++, count--.
  - Partial, we and re: write and read both proceed, count unchanged.
  - Empty, re only: rd_err=1; dout holds; pointers and count unchanged.
  - Empty, we and re: bypass. dout<=din, rd_valid=1; nothing written; pointers and count unchanged.
  - Full, we only: wr_err=1; din dropped; state unchanged.
  - Full, we and re: read mem[rd_ptr] and write din to the same (freed) slot. Old data goes to dout; count stays DEPTH.
  - Empty, we only: normal write. Full, re only: normal read.
- Read latency: 1 cycle (dout/rd_valid valid the cycle after re is sampled).
- dout holds its last value when no read occurs (it is not zeroed).
- rd_err/wr_err and rd_valid are single-cycle pulses, deasserted on any cycle without the triggering condition.
- Pass-through depth: a value written at edge N is readable via re at edge N+1 at earliest.

Decomposition:
- Shared package fifo_pkg:
  - log2 constant function for AW.
  - localparams for state encoding (ST_EMPTY, ST_PARTIAL, ST_FULL).
  - error bit positions (ERR_RD=1, ERR_WR=0).
- One sub-module, fifo_ram:
  - DEPTH x DWIDTH register array.
  - One synchronous write port and one synchronous registered read port.
  - No reset on contents.
- Control, pointers, count and flags live in sync_fifo_param.

Test Plan:
- Reset, then re=1 for 1 cycle (DWIDTH=8, DEPTH=8) -> rd_err pulses 1 cycle, dout=0, count=0, empty=1.
- Write 0x01..0x08 back-to-back -> full=1 after 8th edge, count=8, almost_full=1 from count=6. 9th write -> wr_err pulse, count stays 8.
- Read 8 times from full -> dout sequence 0x01..0x08 with rd_valid each cycle. empty=1 after last read; almost_empty=1 from count=2.
- Write/read wrap: 5 writes, 5 reads, repeated 3x -> data order preserved across pointer wrap, count returns to 0 each round.
- Simultaneous we/re while empty with din=0xA5 -> dout=0xA5, rd_valid=1, count=0, no error. Simultaneous we/re while full -> oldest word out, count=8, no wr_err.
- rst pulsed mid-burst with count=4 -> count=0, empty=1, dout=0 immediately (async). Subsequent read -> rd_err. DEPTH=16, DWIDTH=32 instance passes the same sequences scaled.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and helpers for sync_fifo_param
package fifo_pkg;
  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_PARTIAL = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;
  localparam int ERR_RD = 1;
  localparam int ERR_WR = 0;
  function automatic int log2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: DEPTH x DWIDTH storage with a sync write port and a registered read port
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 8,
  parameter int AW     = log2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              re,
  input  logic              fwd,
  input  logic [AW-1:0]     raddr,
  output logic [DWIDTH-1:0] q
);
  logic [DWIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  // fwd loads write data straight into the output register (empty-FIFO bypass)
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (re) q <= fwd ? wdata : mem[raddr];
endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with fill level, flags and error pulses
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DWIDTH   = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  localparam int AW      = log2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [DWIDTH-1:0] din,
  output logic [DWIDTH-1:0] dout,
  output logic              rd_valid,
  output logic [AW:0]       count,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic              rd_err,
  output logic              wr_err
);
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [1:0] st, err;
  logic do_wr, do_rd, byp;
  assign st = (count == '0) ? ST_EMPTY : (count == (AW+1)'(DEPTH)) ? ST_FULL : ST_PARTIAL;
  assign empty        = st == ST_EMPTY;
  assign full         = st == ST_FULL;
  assign almost_empty = int'(count) <= AE_LEVEL;
  assign almost_full  = int'(count) >= AF_LEVEL;
  assign rd_err       = err[ERR_RD];
  assign wr_err       = err[ERR_WR];
  // a full FIFO accepts a write only when the same cycle frees a slot
  assign do_wr = we && (st == ST_PARTIAL || (st == ST_EMPTY && !re) || (st == ST_FULL && re));
  assign do_rd = re && st != ST_EMPTY;
  assign byp   = we && re && st == ST_EMPTY;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      err      <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      count       <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
      rd_valid    <= do_rd || byp;
      err[ERR_RD] <= re && !we && st == ST_EMPTY;
      err[ERR_WR] <= we && !re && st == ST_FULL;
    end
  fifo_ram #(.DWIDTH(DWIDTH), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (do_wr),
    .waddr(wr_ptr),
    .wdata(din),
    .re   (do_rd || byp),
    .fwd  (byp),
    .raddr(rd_ptr),
    .q    (dout)
  );
endmodule
